// File: rtl/vga_timing_ctrl_if.sv
// Raster timing bundle from vga_timing_ctrl to the renderer and VGA connector.
// The timing generator drives it (master); consumers only observe it (slave).
interface vga_timing_ctrl_if;
  logic        pix_en;
  logic [9:0]  hCount;
  logic [9:0]  vCount;
  logic        hSync;
  logic        vSync;
  logic        bright;
  logic        line_tick;
  logic        frame_tick;
  logic [15:0] frame_count;

  modport master (
    output pix_en, hCount, vCount, hSync, vSync, bright,
           line_tick, frame_tick, frame_count
  );

  modport slave (
    input  pix_en, hCount, vCount, hSync, vSync, bright,
           line_tick, frame_tick, frame_count
  );
endinterface

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator: pixel-rate enable, h/v counters with lockstep
// phase FSMs, registered sync/bright flags and per-line/per-frame strobes.
//
// state   | meaning
// --------+--------------------------------------------
// PH_SYNC | sync pulse asserted (counter 0..SYNC-1)
// PH_BP   | back porch
// PH_ACT  | active video
// PH_FP   | front porch, wraps to PH_SYNC at the total
module vga_timing_ctrl #(
  parameter int CLK_DIV  = 4,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACT    = 640,
  parameter int H_FP     = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACT    = 480,
  parameter int V_FP     = 10,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  vga_timing_ctrl_if.master  vga
);

  localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int DW    = $clog2(CLK_DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  localparam logic [9:0] H_SYNC_END = 10'(H_SYNC - 1);
  localparam logic [9:0] H_BP_END   = 10'(H_SYNC + H_BP - 1);
  localparam logic [9:0] H_ACT_END  = 10'(H_SYNC + H_BP + H_ACT - 1);
  localparam logic [9:0] H_LAST     = 10'(H_TOT - 1);
  localparam logic [9:0] V_SYNC_END = 10'(V_SYNC - 1);
  localparam logic [9:0] V_BP_END   = 10'(V_SYNC + V_BP - 1);
  localparam logic [9:0] V_ACT_END  = 10'(V_SYNC + V_BP + V_ACT - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOT - 1);

  typedef enum logic [1:0] {PH_SYNC, PH_BP, PH_ACT, PH_FP} phase_t;

  phase_t        h_state, v_state;
  phase_t        h_nxt, v_nxt;
  logic [DW-1:0] div;
  logic          h_wrap, v_wrap;

  // Phase boundaries are compared on the counter value about to be left, so
  // the FSM and the counter step together on the same pix_en edge.
  always_comb begin
    h_wrap = vga.pix_en && (vga.hCount == H_LAST);
    v_wrap = h_wrap && (vga.vCount == V_LAST);

    h_nxt = h_state;
    if (vga.pix_en) begin
      case (h_state)
        PH_SYNC: if (vga.hCount == H_SYNC_END) h_nxt = PH_BP;
        PH_BP:   if (vga.hCount == H_BP_END)   h_nxt = PH_ACT;
        PH_ACT:  if (vga.hCount == H_ACT_END)  h_nxt = PH_FP;
        PH_FP:   if (vga.hCount == H_LAST)     h_nxt = PH_SYNC;
        default:                               h_nxt = PH_SYNC;
      endcase
    end

    v_nxt = v_state;
    if (h_wrap) begin
      case (v_state)
        PH_SYNC: if (vga.vCount == V_SYNC_END) v_nxt = PH_BP;
        PH_BP:   if (vga.vCount == V_BP_END)   v_nxt = PH_ACT;
        PH_ACT:  if (vga.vCount == V_ACT_END)  v_nxt = PH_FP;
        PH_FP:   if (vga.vCount == V_LAST)     v_nxt = PH_SYNC;
        default:                               v_nxt = PH_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div             <= '0;
      vga.pix_en      <= 1'b0;
      vga.hCount      <= '0;
      vga.vCount      <= '0;
      h_state         <= PH_SYNC;
      v_state         <= PH_SYNC;
      vga.hSync       <= SYNC_POL;
      vga.vSync       <= SYNC_POL;
      vga.bright      <= 1'b0;
      vga.line_tick   <= 1'b0;
      vga.frame_tick  <= 1'b0;
      vga.frame_count <= '0;
    end else begin
      div            <= (div == DIV_LAST) ? '0 : div + 1'b1;
      vga.pix_en     <= (div == DIV_LAST);
      vga.line_tick  <= h_wrap;
      vga.frame_tick <= v_wrap;
      h_state        <= h_nxt;
      v_state        <= v_nxt;

      if (vga.pix_en) begin
        vga.hCount <= h_wrap ? 10'd0 : vga.hCount + 10'd1;
        if (h_wrap)
          vga.vCount <= v_wrap ? 10'd0 : vga.vCount + 10'd1;
        vga.hSync  <= (h_nxt == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
        vga.vSync  <= (v_nxt == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
        vga.bright <= (h_nxt == PH_ACT) && (v_nxt == PH_ACT);
      end

      if (v_wrap)
        vga.frame_count <= vga.frame_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Scoreboard bench for vga_timing_ctrl on a shrunken raster, with random resets;
// a second instance built with inverted sync polarity is checked alongside.
module tb_vga_timing_ctrl;

  localparam int CLK_DIV = 4;
  localparam int H_SYNC = 5, H_BP = 3, H_ACT = 10, H_FP = 2;
  localparam int V_SYNC = 2, V_BP = 3, V_ACT = 4,  V_FP = 2;
  localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int F_PIX = H_TOT * V_TOT;
  localparam int NCYC  = 30000;

  typedef struct packed {
    logic        pe;
    logic [9:0]  h;
    logic [9:0]  v;
    logic        hs;
    logic        vs;
    logic        br;
    logic        lt;
    logic        ft;
    logic [15:0] fc;
  } obs_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   done = 1'b0;
  obs_t exp_q[$];

  always #5 clk = ~clk;

  vga_timing_ctrl_if bus_n ();
  vga_timing_ctrl_if bus_p ();

  vga_timing_ctrl #(
    .CLK_DIV(CLK_DIV), .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACT(H_ACT), .H_FP(H_FP),
    .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACT(V_ACT), .V_FP(V_FP), .SYNC_POL(1'b0)
  ) dut_n (.clk(clk), .reset(reset), .vga(bus_n));

  vga_timing_ctrl #(
    .CLK_DIV(CLK_DIV), .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACT(H_ACT), .H_FP(H_FP),
    .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACT(V_ACT), .V_FP(V_FP), .SYNC_POL(1'b1)
  ) dut_p (.clk(clk), .reset(reset), .vga(bus_p));

  // Expected active-low outputs after n edges without reset (n = 0 is the reset state).
  function automatic obs_t model(input int n);
    obs_t o;
    int   p, hc, vc;
    bit   adv;
    p   = (n > 0) ? (n - 1) / CLK_DIV : 0;
    adv = (n > CLK_DIV) && ((n - 1) % CLK_DIV == 0);
    hc  = p % H_TOT;
    vc  = (p / H_TOT) % V_TOT;
    o.pe = (n >= CLK_DIV) && (n % CLK_DIV == 0);
    o.h  = 10'(hc);
    o.v  = 10'(vc);
    o.hs = !(hc < H_SYNC);
    o.vs = !(vc < V_SYNC);
    o.br = (hc >= H_SYNC + H_BP) && (hc < H_SYNC + H_BP + H_ACT) &&
           (vc >= V_SYNC + V_BP) && (vc < V_SYNC + V_BP + V_ACT);
    o.lt = adv && (hc == 0);
    o.ft = adv && (p % F_PIX == 0);
    o.fc = 16'((p / F_PIX) % 65536);
    return o;
  endfunction

  task automatic cmp(input string nm, input int cyc, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got pe=%0b h=%0d v=%0d hs=%0b vs=%0b br=%0b lt=%0b ft=%0b fc=%0d exp pe=%0b h=%0d v=%0d hs=%0b vs=%0b br=%0b lt=%0b ft=%0b fc=%0d",
               nm, cyc, got.pe, got.h, got.v, got.hs, got.vs, got.br, got.lt, got.ft, got.fc,
               exp.pe, exp.h, exp.v, exp.hs, exp.vs, exp.br, exp.lt, exp.ft, exp.fc);
    end
  endtask

  // Stimulus: random reset pulses plus one directed mid-frame reset.
  initial begin
    int   n = 0;
    int   hold = 3;
    bit   directed = 1'b0;
    obs_t cur;
    reset = 1'b1;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      if (reset) n = 0;
      else n++;
      cur = model(n);
      exp_q.push_back(cur);
      if (hold > 0) begin
        hold--;
        reset = 1'b1;
      end else if (!directed && c > 4000 && cur.h == 12 && cur.v == 6) begin
        directed = 1'b1;
        reset = 1'b1;
      end else if ($urandom_range(0, 3999) == 0) begin
        hold  = $urandom_range(0, 2);
        reset = 1'b1;
      end else begin
        reset = 1'b0;
      end
    end
    done = 1'b1;
  end

  // Monitor: pop expected state every cycle, plus frame period / bright-count checks.
  initial begin
    int   cyc = 0;
    int   last_ft = -1;
    int   br_cnt = 0;
    bit   br_valid = 1'b0;
    int   frames = 0;
    obs_t e, got_n, got_p, e_p;
    forever begin
      @(negedge clk);
      if (done && exp_q.size() == 0) break;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty cyc=%0d got no expected entry, required one", cyc);
      end else begin
        e = exp_q.pop_front();
        got_n = {bus_n.pix_en, bus_n.hCount, bus_n.vCount, bus_n.hSync, bus_n.vSync,
                 bus_n.bright, bus_n.line_tick, bus_n.frame_tick, bus_n.frame_count};
        got_p = {bus_p.pix_en, bus_p.hCount, bus_p.vCount, bus_p.hSync, bus_p.vSync,
                 bus_p.bright, bus_p.line_tick, bus_p.frame_tick, bus_p.frame_count};
        e_p = e;
        e_p.hs = ~e.hs;
        e_p.vs = ~e.vs;
        cmp("raster_pol0", cyc, got_n, e);
        cmp("raster_pol1", cyc, got_p, e_p);
      end

      if (bus_n.frame_tick === 1'b1) begin
        if (last_ft >= 0) begin
          checks++;
          frames++;
          if (cyc - last_ft != CLK_DIV * F_PIX) begin
            errors++;
            $display("FAIL frame_period got %0d clocks, required %0d", cyc - last_ft, CLK_DIV * F_PIX);
          end
        end
        if (br_valid) begin
          checks++;
          if (br_cnt != H_ACT * V_ACT * CLK_DIV) begin
            errors++;
            $display("FAIL bright_per_frame got %0d clocks, required %0d", br_cnt, H_ACT * V_ACT * CLK_DIV);
          end
        end
        last_ft  = cyc;
        br_cnt   = 0;
        br_valid = 1'b1;
      end
      if (bus_n.bright === 1'b1) br_cnt++;
      if (reset) begin
        last_ft  = -1;
        br_valid = 1'b0;
      end
      cyc++;
    end
    checks++;
    if (frames < 2) begin
      errors++;
      $display("FAIL full_frames got %0d uninterrupted frames, required at least 2", frames);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #(64'(NCYC) * 20 + 1000);
    $display("FAIL watchdog got timeout, required completion within %0d cycles", NCYC);
    $fatal(1, "watchdog expired");
  end

endmodule
